mult_8x8: RTL and testbench

MULT_8X8 -- requirements
Module: mult

---
 rtl/mult_8x8.sv | 73 +++++++
 tb/tb_mult_8x8.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mult_8x8.sv
// mult_8x8: registered unsigned W x W multiplier built from a partial-product adder tree.
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   a, b      unsigned operands (W bits)
//   in_valid  operand pair valid this cycle
//   x         registered product a*b (2*W bits), holds when no new product
//   out_valid one-cycle pulse when x carries a new product
// Optional build macro MULT_PIPE2_EN: registers the low/high partial-product sums,
// raising latency from 1 to 2 clocks at the same throughput.
module mult_8x8 #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           in_valid,
    output logic [2*W-1:0] x,
    output logic           out_valid
);
    localparam int H = W / 2;
    logic [2*W-1:0] pp;
    logic [2*W-1:0] lo_sum;
    logic [2*W-1:0] hi_sum;
    // Partial products for b[0..H-1] feed the low-half sum, the rest the high-half sum.
    always_comb begin
        pp     = '0;
        lo_sum = '0;
        hi_sum = '0;
        for (int i = 0; i < W; i++) begin
            pp = {{W{1'b0}}, a & {W{b[i]}}} << i;
            if (i < H)
                lo_sum = lo_sum + pp;
            else
                hi_sum = hi_sum + pp;
        end
    end
`ifdef MULT_PIPE2_EN
    logic [2*W-1:0] lo_q;
    logic [2*W-1:0] hi_q;
    logic           v_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lo_q      <= '0;
            hi_q      <= '0;
            v_q       <= 1'b0;
            x         <= '0;
            out_valid <= 1'b0;
        end else begin
            v_q       <= in_valid;
            out_valid <= v_q;
            if (in_valid) begin
                lo_q <= lo_sum;
                hi_q <= hi_sum;
            end
            if (v_q)
                x <= lo_q + hi_q;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                x <= lo_sum + hi_sum;
        end
    end
`endif
endmodule

// File: tb/tb_mult_8x8.sv
// tb_mult_8x8: table-driven and sequence checks of mult_8x8 in either build.
module tb_mult_8x8;
`ifdef MULT_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        in_valid = 1'b0;
    logic [15:0] x;
    logic        out_valid;
    int          n_vec = 0;
    int          n_bad = 0;

    mult_8x8 #(.W(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b),
        .in_valid(in_valid), .x(x), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Single product: drive one valid cycle, then look after the build latency.
    task automatic apply(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] exp);
        @(negedge clk);
        a = va; b = vb; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (LAT - 1) @(negedge clk);
        check($sformatf("prod %0d*%0d", va, vb), x, exp);
        check("prod valid", {15'd0, out_valid}, 16'd1);
    endtask

    vec_t vt [11];
    int   pulses;

    initial begin
        vt[0]  = '{8'd0,   8'd0,   16'h0000};
        vt[1]  = '{8'd255, 8'd255, 16'hFE01};
        vt[2]  = '{8'd1,   8'd200, 16'h00C8};
        vt[3]  = '{8'd128, 8'd2,   16'h0100};
        vt[4]  = '{8'd16,  8'd16,  16'h0100};
        vt[5]  = '{8'd0,   8'd77,  16'h0000};
        vt[6]  = '{8'd93,  8'd0,   16'h0000};
        vt[7]  = '{8'd173, 8'd1,   16'h00AD};
        vt[8]  = '{8'd15,  8'd15,  16'h00E1};
        vt[9]  = '{8'd170, 8'd85,  16'h3872};
        vt[10] = '{8'd200, 8'd123, 16'h6018};

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset x", x, 16'h0000);
        check("reset valid", {15'd0, out_valid}, 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++)
            apply(vt[i].a, vt[i].b, vt[i].exp);

        // Hold: x keeps 000F while in_valid is low, out_valid pulses once.
        @(negedge clk);
        a = 8'd3; b = 8'd5; in_valid = 1'b1;
        @(negedge clk);
        a = 8'd7; b = 8'd9; in_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 3 + LAT; c++) begin
            if (c >= LAT - 1) check("hold x", x, 16'h000F);
            pulses += int'(out_valid);
            @(negedge clk);
        end
        check("hold pulses", 16'(pulses), 16'd1);

        // Reset with in_valid high: nothing from the reset cycles survives.
        rst_n = 1'b0; a = 8'd10; b = 8'd10; in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst x", x, 16'h0000);
            check("rst valid", {15'd0, out_valid}, 16'd0);
        end
        rst_n = 1'b1;
        repeat (LAT - 1) begin
            @(negedge clk);
            check("rel early valid", {15'd0, out_valid}, 16'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("rel x", x, 16'h0064);
        check("rel valid", {15'd0, out_valid}, 16'd1);

`ifdef MULT_PIPE2_EN
        // Mid-flight reset drops the 12*12 product.
        @(negedge clk);
        a = 8'd12; b = 8'd12; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        check("mid valid", {15'd0, out_valid}, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check("mid x", x, 16'h0000);
            check("mid valid", {15'd0, out_valid}, 16'd0);
            @(negedge clk);
        end
`endif

        // Exhaustive back-to-back stream.
        for (int k = 0; k < 65536 + LAT; k++) begin
            @(negedge clk);
            if (k >= LAT) begin
                int j;
                j = k - LAT;
                check($sformatf("stream %0d*%0d", j / 256, j % 256), x, 16'((j / 256) * (j % 256)));
                check("stream valid", {15'd0, out_valid}, 16'd1);
            end
            if (k < 65536) begin
                a = 8'(k / 256); b = 8'(k % 256); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("tail valid", {15'd0, out_valid}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
